// File: rtl/time_decode_if.sv
// time_decode_if: request/result bundle between a seconds-count producer
// and the time_decode BCD converter.
interface time_decode_if #(
   parameter int CNT_W = 21
);
   logic             start;
   logic [CNT_W-1:0] count;
   logic             mode;
   logic             busy;
   logic             done;
   logic             range_err;
   logic [3:0]       hour_ten;
   logic [3:0]       hour_one;
   logic [3:0]       min_ten;
   logic [3:0]       min_one;
   logic [3:0]       sec_ten;
   logic [3:0]       sec_one;
   logic             pm;

   modport master (
      output start, count, mode,
      input  busy, done, range_err, hour_ten, hour_one,
             min_ten, min_one, sec_ten, sec_one, pm
   );

   modport slave (
      input  start, count, mode,
      output busy, done, range_err, hour_ten, hour_one,
             min_ten, min_one, sec_ten, sec_one, pm
   );
endinterface

// File: rtl/time_decode.sv
// time_decode: iterative seconds-of-day to BCD HH:MM:SS converter.
// One subtract step per clock: hours, then minutes, 12-hour adjust, then
// parallel tens extraction. Optional macro LEAD_ZERO_BLANK_EN blanks a
// leading zero hour digit (4'hF) in 12-hour mode.
module time_decode #(
   parameter int CNT_W   = 21,
   parameter int DAY_SEC = 86400
) (
   input  logic         clk,
   input  logic         rst_n,
   time_decode_if.slave bus
);
   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_HRS   = 3'd1;
   localparam logic [2:0] S_MIN   = 3'd2;
   localparam logic [2:0] S_ADJ   = 3'd3;
   localparam logic [2:0] S_SPLIT = 3'd4;
   localparam logic [2:0] S_DONE  = 3'd5;

   localparam logic [CNT_W-1:0] SEC_HOUR = CNT_W'(3600);
   localparam logic [CNT_W-1:0] SEC_MIN  = CNT_W'(60);
   localparam logic [CNT_W-1:0] DAY_LIM  = CNT_W'(DAY_SEC);

   logic [2:0]       state;
   logic [CNT_W-1:0] rem;
   logic             mode_q;
   logic             err;
   logic             pm_q;
   logic [4:0]       h;
   logic [5:0]       m;
   logic [5:0]       s;
   logic [3:0]       h_t;
   logic [3:0]       m_t;
   logic [3:0]       s_t;

   // Conversion FSM, datapath and output registers; outputs only update in DONE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= S_IDLE;
         rem           <= '0;
         mode_q        <= 1'b0;
         err           <= 1'b0;
         pm_q          <= 1'b0;
         h             <= '0;
         m             <= '0;
         s             <= '0;
         h_t           <= '0;
         m_t           <= '0;
         s_t           <= '0;
         bus.busy      <= 1'b0;
         bus.done      <= 1'b0;
         bus.range_err <= 1'b0;
         bus.hour_ten  <= '0;
         bus.hour_one  <= '0;
         bus.min_ten   <= '0;
         bus.min_one   <= '0;
         bus.sec_ten   <= '0;
         bus.sec_one   <= '0;
         bus.pm        <= 1'b0;
      end else begin
         bus.done      <= 1'b0;
         bus.range_err <= 1'b0;
         case (state)
            S_IDLE: begin
               if (bus.start) begin
                  mode_q   <= bus.mode;
                  h        <= '0;
                  m        <= '0;
                  s        <= '0;
                  h_t      <= '0;
                  m_t      <= '0;
                  s_t      <= '0;
                  bus.busy <= 1'b1;
                  state    <= S_HRS;
                  // Out-of-range (incl. the transient 86400) shows as midnight.
                  if (bus.count >= DAY_LIM) begin
                     rem <= '0;
                     err <= 1'b1;
                  end else begin
                     rem <= bus.count;
                     err <= 1'b0;
                  end
               end
            end
            S_HRS: begin
               if (rem >= SEC_HOUR) begin
                  rem <= rem - SEC_HOUR;
                  h   <= h + 5'd1;
               end else begin
                  state <= S_MIN;
               end
            end
            S_MIN: begin
               if (rem >= SEC_MIN) begin
                  rem <= rem - SEC_MIN;
                  m   <= m + 6'd1;
               end else begin
                  s     <= rem[5:0];
                  state <= S_ADJ;
               end
            end
            S_ADJ: begin
               pm_q <= (h >= 5'd12);
               if (mode_q) begin
                  if (h == 5'd0)
                     h <= 5'd12;
                  else if (h > 5'd12)
                     h <= h - 5'd12;
               end
               state <= S_SPLIT;
            end
            S_SPLIT: begin
               if (h >= 5'd10) begin
                  h   <= h - 5'd10;
                  h_t <= h_t + 4'd1;
               end
               if (m >= 6'd10) begin
                  m   <= m - 6'd10;
                  m_t <= m_t + 4'd1;
               end
               if (s >= 6'd10) begin
                  s   <= s - 6'd10;
                  s_t <= s_t + 4'd1;
               end
               // busy drops as we enter DONE so it is low by the done pulse.
               if (h < 5'd10 && m < 6'd10 && s < 6'd10) begin
                  bus.busy <= 1'b0;
                  state    <= S_DONE;
               end
            end
            S_DONE: begin
`ifdef LEAD_ZERO_BLANK_EN
               bus.hour_ten <= (mode_q && h_t == 4'd0) ? 4'hF : h_t;
`else
               bus.hour_ten <= h_t;
`endif
               bus.hour_one  <= h[3:0];
               bus.min_ten   <= m_t;
               bus.min_one   <= m[3:0];
               bus.sec_ten   <= s_t;
               bus.sec_one   <= s[3:0];
               bus.pm        <= pm_q;
               bus.done      <= 1'b1;
               bus.range_err <= err;
               state         <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_time_decode.sv
// tb_time_decode: directed + random conversions checked against an
// arithmetic time-of-day model (div/mod), including latency and busy span.
module tb_time_decode;
   logic clk = 1'b0;
   logic rst_n;
   int   checks = 0;
   int   failures = 0;

   time_decode_if #(.CNT_W(21)) bus ();

   time_decode #(.CNT_W(21), .DAY_SEC(86400)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference model: plain div/mod of the seconds-of-day value.
   task automatic model(input int c, input bit md, output logic [23:0] dig,
                        output bit pm_e, output bit err_e, output int lat);
      int cc, hh, mm, ss, hd, ht, mx;
      err_e = (c >= 86400);
      cc    = err_e ? 0 : c;
      hh    = cc / 3600;
      mm    = (cc % 3600) / 60;
      ss    = cc % 60;
      pm_e  = (hh >= 12);
      hd    = hh;
      if (md) hd = (hh == 0) ? 12 : ((hh > 12) ? hh - 12 : hh);
      mx    = hd / 10;
      if (mm / 10 > mx) mx = mm / 10;
      if (ss / 10 > mx) mx = ss / 10;
      lat   = hh + mm + mx + 5;
      ht    = hd / 10;
`ifdef LEAD_ZERO_BLANK_EN
      if (md && ht == 0) ht = 15;
`endif
      dig = {4'(ht), 4'(hd % 10), 4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
   endtask

   function automatic logic [23:0] digits();
      return {bus.hour_ten, bus.hour_one, bus.min_ten, bus.min_one, bus.sec_ten, bus.sec_one};
   endfunction

   // One conversion; optionally pokes start/count/mode mid-flight.
   task automatic run_conv(input int c, input bit md, input bit disturb);
      logic [23:0] dig_e;
      bit pm_e, err_e;
      int lat, n, bsy;
      model(c, md, dig_e, pm_e, err_e, lat);
      @(negedge clk);
      bus.start = 1'b1;
      bus.count = 21'(c);
      bus.mode  = md;
      @(posedge clk); #1;
      bus.start = 1'b0;
      n = 0;
      bsy = bus.busy ? 1 : 0;
      while (!bus.done && n < 200) begin
         if (disturb && n == 10) begin
            bus.start = 1'b1;
            bus.count = 21'($urandom_range(0, 86399));
            bus.mode  = ~md;
         end else if (disturb && n == 11) begin
            bus.start = 1'b0;
         end
         @(posedge clk); #1;
         n++;
         if (bus.busy) bsy++;
      end
      chk($sformatf("timeout c=%0d", c), 32'(n < 200), 32'd1);
      chk($sformatf("latency c=%0d", c), 32'(n), 32'(lat));
      chk($sformatf("busy_span c=%0d", c), 32'(bsy), 32'(lat - 1));
      chk($sformatf("digits c=%0d m=%0d", c, md), 32'(digits()), 32'(dig_e));
      chk($sformatf("pm c=%0d", c), 32'(bus.pm), 32'(pm_e));
      chk($sformatf("range_err c=%0d", c), 32'(bus.range_err), 32'(err_e));
      @(posedge clk); #1;
      chk($sformatf("done_pulse c=%0d", c), 32'({bus.done, bus.range_err}), 32'd0);
      chk($sformatf("hold c=%0d", c), 32'(digits()), 32'(dig_e));
   endtask

   initial begin
      int ndone;
      bus.start = 1'b0;
      bus.count = '0;
      bus.mode  = 1'b0;
      rst_n     = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset_outs", 32'({bus.busy, bus.done, bus.range_err, bus.pm}), 32'd0);
      chk("reset_digits", 32'(digits()), 32'd0);
      rst_n = 1'b1;

      // Directed corner cases.
      run_conv(0, 1'b0, 1'b0);
      run_conv(86399, 1'b0, 1'b0);
      run_conv(46800, 1'b1, 1'b0);
      run_conv(0, 1'b1, 1'b0);
      run_conv(86400, 1'b0, 1'b0);
      run_conv(100000, 1'b1, 1'b0);
      run_conv(3661, 1'b0, 1'b0);
      run_conv(43200, 1'b1, 1'b0);
      run_conv(75599, 1'b1, 1'b0);

      // Restart attempt and input change mid-conversion: single done only.
      run_conv(50000, 1'b0, 1'b1);
      ndone = 0;
      repeat (100) begin
         @(posedge clk); #1;
         if (bus.done) ndone++;
      end
      chk("no_second_done", 32'(ndone), 32'd0);

      // Reset in the middle of HRS aborts without done.
      @(negedge clk);
      bus.start = 1'b1;
      bus.count = 21'(80000);
      bus.mode  = 1'b0;
      @(posedge clk); #1;
      bus.start = 1'b0;
      repeat (5) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("midrst_busy", 32'({bus.busy, bus.done}), 32'd0);
      chk("midrst_digits", 32'(digits()), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      ndone = 0;
      repeat (120) begin
         @(posedge clk); #1;
         if (bus.done || bus.busy) ndone++;
      end
      chk("midrst_no_done", 32'(ndone), 32'd0);
      run_conv(3661, 1'b0, 1'b0);

      // Random conversions, some out of range.
      for (int i = 0; i < 25; i++)
         run_conv(int'($urandom_range(0, 99999)), 1'($urandom_range(0, 1)), 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
